// File: rtl/cordic_sequencer.sv
// cordic_sequencer: iterative rotation-mode CORDIC, one micro-rotation per clock
// Ports: clk_i/rst_i clock and sync active-high reset; start_i request (ignored while busy_o);
//        x_i/y_i/z_i operands taken on accepted start; busy_o high in RUN; done_o one-cycle
//        completion strobe; x_o/y_o/z_o working registers (result x, result y, residual angle).

// cordic_asr: arithmetic right barrel shifter, sign fill
module cordic_asr #(
    parameter int Width = 16
) (
    input  logic [Width-1:0] a_i,
    input  logic [3:0]       sh_i,
    output logic [Width-1:0] q_o
);
    assign q_o = $signed(a_i) >>> sh_i;
endmodule

module cordic_sequencer #(
    parameter int Width      = 16,
    parameter int Iterations = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [Width-1:0] x_i,
    input  logic [Width-1:0] y_i,
    input  logic [Width-1:0] z_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [Width-1:0] x_o,
    output logic [Width-1:0] y_o,
    output logic [Width-1:0] z_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [3:0]       iter_q, iter_d;
    logic [Width-1:0] x_q, x_d, y_q, y_d, z_q, z_d, x_sh, y_sh;
    logic [Width-1:0] atan_tab [16];
    logic             accept, last, neg;
    // atan(2^-i) in radians, rounded into Q3.(Width-3) at elaboration
    function automatic logic [Width-1:0] atan_c(input int i);
        real a;
        case (i)
            0:       a = 0.7853981633974483;
            1:       a = 0.4636476090008061;
            2:       a = 0.24497866312686414;
            3:       a = 0.12435499454676144;
            4:       a = 0.06241880999595735;
            5:       a = 0.031239833430268277;
            6:       a = 0.015623728620476831;
            7:       a = 0.007812341060101111;
            8:       a = 0.0039062301319669718;
            9:       a = 0.0019531225164788188;
            10:      a = 0.0009765621895593195;
            11:      a = 0.0004882812111948983;
            12:      a = 0.00024414062014936177;
            13:      a = 0.00012207031189367021;
            14:      a = 0.00006103515617420877;
            15:      a = 0.000030517578115526096;
            default: a = 0.0;
        endcase
        return Width'($rtoi(a * $itor(1 << (Width - 3)) + 0.5));
    endfunction
    for (genvar g = 0; g < 16; g++) begin : g_atan
        localparam logic [Width-1:0] A = atan_c(g);
        assign atan_tab[g] = A;
    end
    cordic_asr #(.Width(Width)) u_xsh (.a_i(x_q), .sh_i(iter_q), .q_o(x_sh));
    cordic_asr #(.Width(Width)) u_ysh (.a_i(y_q), .sh_i(iter_q), .q_o(y_sh));
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            iter_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
        end
    end
    // IDLE and DONE accept a start identically, which gives back-to-back operation
    always_comb begin
        accept  = start_i && state_q != RUN;
        last    = iter_q == 4'(Iterations - 1);
        state_d = state_q == RUN ? (last ? DONE : RUN) : (start_i ? RUN : IDLE);
    end
    always_comb begin
        neg    = z_q[Width-1];
        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        iter_d = iter_q;
        if (accept) begin
            x_d    = x_i;
            y_d    = y_i;
            z_d    = z_i;
            iter_d = '0;
        end else if (state_q == RUN) begin
            x_d    = neg ? x_q + y_sh : x_q - y_sh;
            y_d    = neg ? y_q - x_sh : y_q + x_sh;
            z_d    = neg ? z_q + atan_tab[iter_q] : z_q - atan_tab[iter_q];
            iter_d = iter_q + 4'd1;
        end
    end
    always_comb begin
        busy_o = state_q == RUN;
        done_o = state_q == DONE;
        x_o    = x_q;
        y_o    = y_q;
        z_o    = z_q;
    end
endmodule

// File: tb/tb_cordic_sequencer.sv
// tb_cordic_sequencer: directed table-driven bench for cordic_sequencer
module tb_cordic_sequencer;
    localparam int W = 16;
    logic         clk = 1'b0;
    logic         rst, start, busy, done;
    logic [W-1:0] xi, yi, zi, xo, yo, zo;
    int           checks = 0;
    int           errors = 0;
    typedef struct {
        int x, y, z, ex, ey, ez;
    } vec_t;
    vec_t vt [7];

    cordic_sequencer #(.Width(W), .Iterations(16)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .x_i(xi), .y_i(yi), .z_i(zi),
        .busy_o(busy), .done_o(done),
        .x_o(xo), .y_o(yo), .z_o(zo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input int act, input int exp, input int tol);
        checks++;
        if (act > exp + tol || act < exp - tol) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (+-%0d)", n, act, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sv(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic wait_done(input string n, output int lat);
        bit ov;
        ov  = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
            if (busy && done) ov = 1'b1;
        end
        chk({n, " busy_done_overlap"}, int'(ov), 0, 0);
    endtask

    task automatic drive(input vec_t v);
        xi = W'(v.x);
        yi = W'(v.y);
        zi = W'(v.z);
    endtask

    task automatic chk_res(input string n, input vec_t v);
        chk({n, " x"}, sv(xo), v.ex, 4);
        chk({n, " y"}, sv(yo), v.ey, 4);
        chk({n, " z"}, sv(zo), v.ez, 2);
    endtask

    task automatic apply(input string n, input vec_t v);
        int lat;
        drive(v);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({n, " busy_after_accept"}, int'(busy), 1, 0);
        wait_done(n, lat);
        chk({n, " latency"}, lat, 16, 0);
        chk_res(n, v);
    endtask

    initial begin
        int   lat;
        bit   bad;
        vt[0] = '{9949, 0, 0, 16384, 0, 0};
        vt[1] = '{9949, 0, 12868, 0, 16384, 0};
        vt[2] = '{9949, 0, -6434, 11585, -11585, 0};
        vt[3] = '{9949, 0, 6434, 11585, 11585, 0};
        vt[4] = '{9949, 0, -12868, 0, -16384, 0};
        vt[5] = '{0, 9949, 0, 0, 16384, 0};
        vt[6] = '{4974, 0, 0, 8191, 0, 0};
        rst   = 1'b1;
        start = 1'b1;
        xi    = 16'd9949;
        yi    = 16'd1;
        zi    = 16'd1;
        tick();
        tick();
        chk("reset busy", int'(busy), 0, 0);
        chk("reset done", int'(done), 0, 0);
        chk("reset x", sv(xo), 0, 0);
        chk("reset y", sv(yo), 0, 0);
        chk("reset z", sv(zo), 0, 0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) apply($sformatf("vec%0d", i), vt[i]);
        tick();
        chk("done single cycle", int'(done), 0, 0);
        chk("idle after done busy", int'(busy), 0, 0);
        // second start during RUN must be dropped
        drive(vt[0]);
        start = 1'b1;
        tick();
        start = 1'b0;
        bad   = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            if (k == 6) begin
                drive(vt[1]);
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            if (!busy || done) bad = 1'b1;
        end
        chk("ignore busy held", int'(bad), 0, 0);
        tick();
        chk("ignore done at 16", int'(done), 1, 0);
        chk_res("ignore result", vt[0]);
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done || busy) bad = 1'b1;
        end
        chk("ignore not queued", int'(bad), 0, 0);
        // reset in the middle of RUN
        drive(vt[1]);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy", int'(busy), 0, 0);
        chk("abort done", int'(done), 0, 0);
        chk("abort x", sv(xo), 0, 0);
        chk("abort y", sv(yo), 0, 0);
        chk("abort z", sv(zo), 0, 0);
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done || busy) bad = 1'b1;
        end
        chk("abort no done", int'(bad), 0, 0);
        apply("after abort", vt[2]);
        tick();
        // start held high: each DONE cycle accepts the next operand set
        drive(vt[3]);
        start = 1'b1;
        tick();
        for (int j = 0; j < 3; j++) begin
            wait_done($sformatf("b2b%0d", j), lat);
            chk($sformatf("b2b%0d latency", j), lat, 16, 0);
            chk_res($sformatf("b2b%0d", j), vt[3+j]);
            if (j < 2) drive(vt[4+j]);
            else start = 1'b0;
            tick();
            chk($sformatf("b2b%0d busy next", j), int'(busy), j < 2 ? 1 : 0, 0);
        end
        chk("b2b final done low", int'(done), 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
